// File: rtl/perf_traffic_gen.sv
// -----------------------------------------------------------------------------
// perf_traffic_gen
//
// Purpose:
//   Synthetic AXI-Stream packet generator for performance measurement. Packets
//   are launched round-robin over the enabled flow classes. Each packet carries
//   a sequence number and a beat index in its data, and a launch timestamp on
//   a sideband. The generator keeps per-class and total packet counters.
//
// Optional feature (compile-time macro):
//   PERF_TX_STALL_STATS_EN - when defined, stat_stall_cycles counts the cycles
//                            with tvalid=1 and tready=0 (wraps at 2^32). When
//                            undefined, the output is tied to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   timestamp             free-running time base, latched at packet launch
//   cfg_enable            run enable (level)
//   cfg_class_mask        enabled flow classes 0..4
//   cfg_pkt_beats         packet length in beats (0 = no launch)
//   cfg_gap               idle cycles inserted after each packet
//   cfg_pkt_limit         number of packets to send (0 = unlimited)
//   m_axis_*              generated stream (tdata/tkeep/tvalid/tready/tlast)
//   m_axis_ts             launch timestamp of the current packet
//   m_axis_flow_class     class number of the current packet (binary, 0..4)
//   stat_sel              class select for stat_pkt_count (>4 reads 0)
//   stat_pkt_count        packets sent for the selected class
//   stat_total_pkts       packets sent in total
//   stat_stall_cycles     backpressure cycles (optional feature)
//   busy                  FSM is not IDLE
//   done                  packet limit reached
// -----------------------------------------------------------------------------
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 64
`endif

module perf_traffic_gen #(
   parameter int AXIS_DATA_WIDTH = 256,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [`PANIC_DESC_TS_SIZE-1:0] timestamp,
   input  logic                           cfg_enable,
   input  logic [4:0]                     cfg_class_mask,
   input  logic [7:0]                     cfg_pkt_beats,
   input  logic [15:0]                    cfg_gap,
   input  logic [31:0]                    cfg_pkt_limit,
   output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]     m_axis_tkeep,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [`PANIC_DESC_TS_SIZE-1:0] m_axis_ts,
   output logic [4:0]                     m_axis_flow_class,
   input  logic [2:0]                     stat_sel,
   output logic [31:0]                    stat_pkt_count,
   output logic [31:0]                    stat_total_pkts,
   output logic [31:0]                    stat_stall_cycles,
   output logic                           busy,
   output logic                           done
);

   localparam int TS_W = `PANIC_DESC_TS_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q,  state_d;
   logic              tvalid_q, tvalid_d;
   logic [7:0]        beat_q,   beat_d;
   logic [7:0]        beats_q,  beats_d;
   logic [31:0]       seq_q,    seq_d;
   logic [TS_W-1:0]   ts_q,     ts_d;
   logic [2:0]        class_q,  class_d;
   logic [2:0]        rr_last_q, rr_last_d;
   logic [15:0]       gap_cnt_q, gap_cnt_d;
   logic [31:0]       total_q,  total_d;
   logic [31:0]       cls_cnt_q [5];
   logic [31:0]       cls_cnt_d [5];

   logic              hs_s;
   logic              last_beat_s;
   logic              limit_hit_s;
   logic              start_ok_s;
   logic [2:0]        pick_s;

   // Round-robin search: first enabled class strictly after 'last', wrapping 4->0.
   function automatic logic [2:0] rr_pick(input logic [4:0] mask, input logic [2:0] last);
      logic [2:0] c;
      logic       found;
      rr_pick = 3'd0;
      found   = 1'b0;
      c       = last;
      for (int i = 0; i < 5; i++) begin
         c = (c >= 3'd4) ? 3'd0 : (c + 3'd1);
         if (!found && mask[c]) begin
            rr_pick = c;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   assign hs_s        = tvalid_q & m_axis_tready;
   assign last_beat_s = (beat_q == (beats_q - 8'd1));
   assign limit_hit_s = (cfg_pkt_limit != 32'd0) && (total_q >= cfg_pkt_limit);
   assign start_ok_s  = cfg_enable && (cfg_class_mask != 5'd0) &&
                        (cfg_pkt_beats != 8'd0) && !limit_hit_s;
   assign pick_s      = rr_pick(cfg_class_mask, rr_last_q);

   // Next-state and datapath update logic for the generator FSM.
   always_comb begin
      state_d   = state_q;
      tvalid_d  = tvalid_q;
      beat_d    = beat_q;
      beats_d   = beats_q;
      seq_d     = seq_q;
      ts_d      = ts_q;
      class_d   = class_q;
      rr_last_d = rr_last_q;
      gap_cnt_d = gap_cnt_q;
      total_d   = total_q;
      for (int i = 0; i < 5; i++) begin
         cls_cnt_d[i] = cls_cnt_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            // Launch: everything describing the packet is captured here so that
            // config changes mid-packet have no effect until the next decision.
            if (start_ok_s) begin
               state_d   = ST_SEND;
               tvalid_d  = 1'b1;
               beat_d    = 8'd0;
               beats_d   = cfg_pkt_beats;
               seq_d     = total_q;
               ts_d      = timestamp;
               class_d   = pick_s;
               rr_last_d = pick_s;
            end else if (cfg_enable && limit_hit_s) begin
               // Gated by enable so that DONE->IDLE on enable=0 does not bounce back.
               state_d   = ST_DONE;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (hs_s) begin
               if (last_beat_s) begin
                  tvalid_d = 1'b0;
                  total_d  = total_q + 32'd1;
                  for (int i = 0; i < 5; i++) begin
                     if (class_q == 3'(i)) begin
                        cls_cnt_d[i] = cls_cnt_q[i] + 32'd1;
                     end else begin
                        cls_cnt_d[i] = cls_cnt_q[i];
                     end
                  end
                  if (cfg_gap != 16'd0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = cfg_gap;
                  end else begin
                     state_d   = ST_IDLE;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end else begin
               // Stalled: all beat attributes hold.
               beat_d = beat_q;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q <= 16'd1) begin
               state_d   = ST_IDLE;
               gap_cnt_d = 16'd0;
            end else begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end
         ST_DONE: begin
            if (!cfg_enable) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any packet in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tvalid_q  <= 1'b0;
         beat_q    <= 8'd0;
         beats_q   <= 8'd0;
         seq_q     <= 32'd0;
         ts_q      <= '0;
         class_q   <= 3'd0;
         rr_last_q <= 3'd4;
         gap_cnt_q <= 16'd0;
         total_q   <= 32'd0;
         for (int i = 0; i < 5; i++) begin
            cls_cnt_q[i] <= 32'd0;
         end
      end else begin
         state_q   <= state_d;
         tvalid_q  <= tvalid_d;
         beat_q    <= beat_d;
         beats_q   <= beats_d;
         seq_q     <= seq_d;
         ts_q      <= ts_d;
         class_q   <= class_d;
         rr_last_q <= rr_last_d;
         gap_cnt_q <= gap_cnt_d;
         total_q   <= total_d;
         for (int i = 0; i < 5; i++) begin
            cls_cnt_q[i] <= cls_cnt_d[i];
         end
      end
   end

   // Beat payload built from registered packet state only.
   always_comb begin
      m_axis_tdata        = '0;
      m_axis_tdata[31:0]  = seq_q;
      m_axis_tdata[39:32] = beat_q;
   end

   assign m_axis_tkeep      = '1;
   assign m_axis_tvalid     = tvalid_q;
   assign m_axis_tlast      = tvalid_q & last_beat_s;
   assign m_axis_ts         = ts_q;
   assign m_axis_flow_class = {2'b00, class_q};
   assign stat_total_pkts   = total_q;
   assign busy              = (state_q != ST_IDLE);
   assign done              = (state_q == ST_DONE);

   // Per-class counter readback mux; out-of-range selects read 0.
   always_comb begin
      case (stat_sel)
         3'd0:    stat_pkt_count = cls_cnt_q[0];
         3'd1:    stat_pkt_count = cls_cnt_q[1];
         3'd2:    stat_pkt_count = cls_cnt_q[2];
         3'd3:    stat_pkt_count = cls_cnt_q[3];
         3'd4:    stat_pkt_count = cls_cnt_q[4];
         default: stat_pkt_count = 32'd0;
      endcase
   end

`ifdef PERF_TX_STALL_STATS_EN
   logic [31:0] stall_q;

   // Backpressure cycle counter, free-wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 32'd0;
      end else if (tvalid_q && !m_axis_tready) begin
         stall_q <= stall_q + 32'd1;
      end else begin
         stall_q <= stall_q;
      end
   end

   assign stat_stall_cycles = stall_q;
`else
   assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/perf_traffic_gen.md
PERF_TRAFFIC_GEN -- requirements
Module: perf_traffic_gen

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 256, master stream data width in bits (minimum 64).
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-004 SHALL have timestamp  in  `PANIC_DESC_TS_SIZE  free-running time base.
REQ-005 SHALL have cfg_enable  in  1  generator run enable (level).
REQ-006 SHALL have cfg_class_mask  in  5  enabled flow classes 0..4.
REQ-007 SHALL have cfg_pkt_beats  in  8  packet length in beats; 0 = invalid, no start.
REQ-008 SHALL have cfg_gap  in  16  idle cycles between packets.
REQ-009 SHALL have cfg_pkt_limit  in  32  packets to send; 0 = unlimited.
REQ-010 SHALL have m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/1/1/1  generated stream.
REQ-011 SHALL have m_axis_ts  out  `PANIC_DESC_TS_SIZE  packet launch timestamp; m_axis_flow_class  out  5  packet class.
REQ-012 SHALL have stat_sel  in  3  class select; stat_pkt_count  out  32  packets sent for selected class; stat_total_pkts  out  32  all packets sent; stat_stall_cycles  out  32  backpressure cycles; busy  out  1  FSM not IDLE; done  out  1  limit reached.

Function
REQ-013 SHALL implement FSM IDLE, SEND, GAP, DONE.
REQ-014 IDLE->SEND when cfg_enable=1, cfg_class_mask!=0, cfg_pkt_beats!=0 and (cfg_pkt_limit=0 or stat_total_pkts<cfg_pkt_limit); IDLE->DONE when limit!=0 and stat_total_pkts>=limit.
REQ-015 On IDLE->SEND edge SHALL latch timestamp into m_axis_ts, cfg_pkt_beats, and next class; m_axis_tvalid rises the following cycle (1-cycle launch latency).
REQ-016 Class selection SHALL be round-robin: first enabled class after last-sent class in order 0,1,2,3,4,0; after reset the search starts at class 0.
REQ-017 Beat content: tdata[31:0]=packet sequence number (=stat_total_pkts at launch), tdata[39:32]=beat index, remaining bits 0; tkeep all ones; tlast when beat index = latched beats-1.
REQ-018 While tvalid=1 and tready=0, tdata, tkeep, tlast, m_axis_ts and m_axis_flow_class SHALL hold stable; tvalid SHALL never drop mid-packet.
REQ-019 m_axis_ts and m_axis_flow_class SHALL remain constant for all beats of a packet.
REQ-020 On last-beat handshake SHALL increment stat_total_pkts and the class counter, then go GAP if cfg_gap!=0 else IDLE.
REQ-021 GAP SHALL last exactly cfg_gap cycles (sampled on entry) with tvalid=0, then IDLE.
REQ-022 cfg_enable deasserted mid-packet SHALL NOT truncate; packet completes, then IDLE/GAP.
REQ-023 DONE: done=1, tvalid=0; DONE->IDLE when cfg_enable=0; counters retained.
REQ-024 Counters SHALL wrap modulo 2^32; stat_pkt_count SHALL be combinational from stat_sel; stat_sel>4 returns 0.
REQ-025 Config changes during SEND/GAP SHALL take effect only at the next IDLE decision.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, m_axis_ts=0, m_axis_flow_class=0, all counters 0, busy=0, done=0, round-robin pointer to class 4 (so first pick searches from 0).
REQ-027 Reset mid-packet SHALL abandon the packet; no partial counter update.

Configuration
REQ-028 Macro PERF_TX_STALL_STATS_EN defined: stat_stall_cycles SHALL count cycles with tvalid=1 and tready=0, wrapping at 2^32.
REQ-029 Macro PERF_TX_STALL_STATS_EN undefined: stat_stall_cycles SHALL be tied to 0 and no counter logic instantiated.

Verification
REQ-030 mask=5'b00101, beats=3, gap=0, limit=4, tready=1 -> classes 0,2,0,2; 12 beats, tlast on beats 2,5,8,11; total=4, done=1, class0=2, class2=2.
REQ-031 beats=2, gap=5, tready=1 -> exactly 5 idle cycles after each tlast plus 1 IDLE decision cycle before next tvalid.
REQ-032 tready low 3 cycles on beat 1 -> beat data/ts held stable; stall count=3 (with macro), 0 (without).
REQ-033 cfg_enable dropped on beat 0 of 4-beat packet -> all 4 beats sent, then idle, busy=0.
REQ-034 timestamp=1000 at launch edge, incrementing -> m_axis_ts=1000 on every beat of that packet.
REQ-035 rst_n asserted during beat 1 -> tvalid=0 immediately, counters 0; post-release first packet class 0, seq 0.
